enigma_rotor_bank: RTL and testbench

Parametrised, multi-cycle Enigma scrambler: a stack of NUM_ROTORS stepping rotors with selectable wiring, ring settings and notch-driven double stepping, followed by a fixed UKW-B reflector. It consumes one letter per valid/ready handshake. It steps the rotors, routes the letter forward, reflects it, routes it back, and presents the cipher letter on a valid/ready output. It sits between the keyboard/letter-entry logic and the lampboard/display logic.

---
 rtl/enigma_rotor_bank.sv | 275 +++++++++++++++++++++++++++
 tb/tb_enigma_rotor_bank.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/enigma_rotor_bank.sv
// enigma_rotor_bank: multi-cycle Enigma scrambler. It has NUM_ROTORS stepping
// rotors (rotor 0 rightmost/fastest) and a fixed UKW-B reflector. It takes one
// letter per in_valid/in_ready handshake and returns the cipher letter on an
// out_valid/out_ready handshake.
module enigma_rotor_bank #(
    parameter int unsigned NUM_ROTORS = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load_en,
    input  logic [5*NUM_ROTORS-1:0]   load_pos,
    input  logic [5*NUM_ROTORS-1:0]   ring_setting,
    input  logic [2*NUM_ROTORS-1:0]   wiring_sel,
    input  logic                      in_valid,
    input  logic [4:0]                in_letter,
    output logic                      in_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [4:0]                out_letter,
    output logic [5*NUM_ROTORS-1:0]   positions
);

    // Wiring tables as ASCII strings; character 0 sits in the top byte.
    localparam logic [8*26-1:0] WIRE_I   = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
    localparam logic [8*26-1:0] WIRE_II  = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
    localparam logic [8*26-1:0] WIRE_III = "BDFHJLCPRTXVZNYEIWGAKMUSQO";
    localparam logic [8*26-1:0] UKW_B    = "YRUHQSLDPXNGOKMIEBFZCWVJAT";

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROTORS - 1);

    typedef enum logic [2:0] {
        IDLE,
        STEP,
        FWD,
        REFL,
        BWD,
        DONE
    } state_t;

    // Look up entry k (0..25) of a 26-letter table; out-of-range passes through.
    function automatic logic [4:0] char_at(input logic [8*26-1:0] tbl, input logic [4:0] k);
        logic [7:0] ch;
        if (k > 5'd25) begin
            return k;
        end
        ch = tbl[8*(25 - int'(k)) +: 8];
        return 5'(ch - 8'd65);
    endfunction

    function automatic logic [4:0] rotor_fwd(input logic [1:0] sel, input logic [4:0] x);
        case (sel)
            2'd0:    return char_at(WIRE_I, x);
            2'd1:    return char_at(WIRE_II, x);
            2'd2:    return char_at(WIRE_III, x);
            default: return x;
        endcase
    endfunction

    // Inverse wiring found by searching the forward table.
    function automatic logic [4:0] rotor_bwd(input logic [1:0] sel, input logic [4:0] x);
        logic [4:0] r;
        r = x;
        if (sel != 2'd3) begin
            for (int unsigned j = 0; j < 26; j++) begin
                if (rotor_fwd(sel, 5'(j)) == x) begin
                    r = 5'(j);
                end
            end
        end
        return r;
    endfunction

    function automatic logic [4:0] notch_of(input logic [1:0] sel);
        case (sel)
            2'd0:    return 5'd16;  // Q
            2'd1:    return 5'd4;   // E
            2'd2:    return 5'd21;  // V
            default: return 5'd25;  // Z
        endcase
    endfunction

    function automatic logic [5:0] add26(input logic [5:0] a, input logic [5:0] b);
        logic [5:0] s;
        s = a + b;
        if (s >= 6'd26) begin
            s = s - 6'd26;
        end
        return s;
    endfunction

    function automatic logic [5:0] sub26(input logic [5:0] a, input logic [5:0] b);
        if (a >= b) begin
            return a - b;
        end
        return a + 6'd26 - b;
    endfunction

    function automatic logic [4:0] fold26(input logic [4:0] v);
        return (v >= 5'd26) ? v - 5'd26 : v;
    endfunction

    state_t      r_state;
    state_t      w_next;
    logic        w_accept;

    logic [4:0]  r_pos  [NUM_ROTORS];
    logic [4:0]  r_ring [NUM_ROTORS];
    logic [1:0]  r_sel  [NUM_ROTORS];
    logic [4:0]  r_c;
    logic        r_bypass;
    logic [3:0]  r_idx;

    logic [NUM_ROTORS-1:0] w_step;
    logic [4:0]  w_cur_pos;
    logic [4:0]  w_cur_ring;
    logic [1:0]  w_cur_sel;
    logic [5:0]  w_s;
    logic [4:0]  w_fwd_in;
    logic [4:0]  w_fwd_c;
    logic [4:0]  w_bwd_c;
    logic [4:0]  w_refl_c;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        w_accept  = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = !reset;
                w_accept = in_valid && !reset;
                if (w_accept) begin
                    w_next = STEP;
                end
            end
            STEP: w_next = FWD;
            FWD: begin
                if (r_idx == LAST_IDX) begin
                    w_next = REFL;
                end
            end
            REFL: w_next = BWD;
            BWD: begin
                if (r_idx == 4'd0) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Step enables, evaluated on the pre-step positions; middle rotors double-step.
    always_comb begin
        w_step    = '0;
        w_step[0] = 1'b1;
        for (int unsigned i = 1; i < NUM_ROTORS; i++) begin
            if (r_pos[i-1] == notch_of(r_sel[i-1])) begin
                w_step[i] = 1'b1;
            end
            if ((i + 2 <= NUM_ROTORS) && (r_pos[i] == notch_of(r_sel[i]))) begin
                w_step[i] = 1'b1;
            end
        end
    end

    // Substitution through the rotor selected by r_idx, plus the reflector.
    always_comb begin
        w_cur_pos  = '0;
        w_cur_ring = '0;
        w_cur_sel  = '0;
        for (int unsigned i = 0; i < NUM_ROTORS; i++) begin
            if (r_idx == 4'(i)) begin
                w_cur_pos  = r_pos[i];
                w_cur_ring = r_ring[i];
                w_cur_sel  = r_sel[i];
            end
        end
        w_s      = sub26({1'b0, w_cur_pos}, {1'b0, w_cur_ring});
        w_fwd_in = 5'(add26({1'b0, r_c}, w_s));
        w_fwd_c  = 5'(sub26({1'b0, rotor_fwd(w_cur_sel, w_fwd_in)}, w_s));
        w_bwd_c  = 5'(sub26({1'b0, rotor_bwd(w_cur_sel, w_fwd_in)}, w_s));
        w_refl_c = char_at(UKW_B, r_c);
    end

    // Datapath: latch on accept, load, step, and walk the letter through the rotors.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_ROTORS; i++) begin
                r_pos[i]  <= '0;
                r_ring[i] <= '0;
                r_sel[i]  <= '0;
            end
            r_c      <= '0;
            r_bypass <= 1'b0;
            r_idx    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_c      <= in_letter;
                        r_bypass <= (in_letter >= 5'd26);
                        r_idx    <= '0;
                        for (int unsigned i = 0; i < NUM_ROTORS; i++) begin
                            r_ring[i] <= fold26(ring_setting[5*i +: 5]);
                            r_sel[i]  <= wiring_sel[2*i +: 2];
                        end
                    end else if (load_en) begin
                        for (int unsigned i = 0; i < NUM_ROTORS; i++) begin
                            r_pos[i] <= fold26(load_pos[5*i +: 5]);
                        end
                    end
                end
                STEP: begin
                    if (!r_bypass) begin
                        for (int unsigned i = 0; i < NUM_ROTORS; i++) begin
                            if (w_step[i]) begin
                                r_pos[i] <= (r_pos[i] == 5'd25) ? 5'd0 : r_pos[i] + 5'd1;
                            end
                        end
                    end
                end
                FWD: begin
                    if (!r_bypass) begin
                        r_c <= w_fwd_c;
                    end
                    if (r_idx != LAST_IDX) begin
                        r_idx <= r_idx + 4'd1;
                    end
                end
                REFL: begin
                    if (!r_bypass) begin
                        r_c <= w_refl_c;
                    end
                    r_idx <= LAST_IDX;
                end
                BWD: begin
                    if (!r_bypass) begin
                        r_c <= w_bwd_c;
                    end
                    if (r_idx != 4'd0) begin
                        r_idx <= r_idx - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Pack rotor positions for the display.
    always_comb begin
        positions = '0;
        for (int unsigned i = 0; i < NUM_ROTORS; i++) begin
            positions[5*i +: 5] = r_pos[i];
        end
    end

    assign out_letter = r_c;

endmodule

// File: tb/tb_enigma_rotor_bank.sv
// Directed testbench for enigma_rotor_bank with NUM_ROTORS=3, using a
// scoreboard queue of expected cipher letters.
module tb_enigma_rotor_bank;

    localparam int unsigned N = 3;

    logic            clk;
    logic            reset;
    logic            load_en;
    logic [5*N-1:0]  load_pos;
    logic [5*N-1:0]  ring_setting;
    logic [2*N-1:0]  wiring_sel;
    logic            in_valid;
    logic [4:0]      in_letter;
    logic            in_ready;
    logic            out_valid;
    logic            out_ready;
    logic [4:0]      out_letter;
    logic [5*N-1:0]  positions;

    enigma_rotor_bank #(.NUM_ROTORS(N)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_en      (load_en),
        .load_pos     (load_pos),
        .ring_setting (ring_setting),
        .wiring_sel   (wiring_sel),
        .in_valid     (in_valid),
        .in_letter    (in_letter),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_letter   (out_letter),
        .positions    (positions)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [4:0]     exp_q [$];
    int             last_lat;
    logic [5*N-1:0] pos_e0;
    logic [5*N-1:0] pos_e1;

    logic [4:0] bdzgo [5] = '{5'd1, 5'd3, 5'd25, 5'd6, 5'd14};
    logic [4:0] rt_in [4] = '{5'd7, 5'd4, 5'd11, 5'd14};

    function automatic logic [14:0] p3(input int l2, input int l1, input int l0);
        return {5'(l2), 5'(l1), 5'(l0)};
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse_load(input logic [14:0] p);
        load_pos = p;
        load_en  = 1'b1;
        @(negedge clk);
        load_en  = 1'b0;
    endtask

    // One transaction; load_mode 1 pokes load_en mid-transaction, 2 at the accept edge.
    task automatic run_txn(input string tag, input logic [4:0] letter, input int load_mode,
                           input logic check_out, input logic [4:0] exp,
                           output logic [4:0] got);
        int   guard;
        int   lat;
        logic rdy0;
        if (check_out) exp_q.push_back(exp);
        in_letter = letter;
        in_valid  = 1'b1;
        if (load_mode == 2) begin
            load_pos = p3(9, 9, 9);
            load_en  = 1'b1;
        end
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk({tag, "_accept_timeout"}, guard, 0);
        @(negedge clk);
        in_valid = 1'b0;
        load_en  = 1'b0;
        lat      = 0;
        pos_e0   = positions;
        rdy0     = in_ready;
        pos_e1   = positions;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat == 1) pos_e1 = positions;
            if (load_mode == 1 && lat == 1) begin
                load_pos = p3(9, 9, 9);
                load_en  = 1'b1;
            end
            if (lat == 3) load_en = 1'b0;
        end
        load_en  = 1'b0;
        last_lat = lat;
        got      = out_letter;
        chk({tag, "_busy"}, int'(rdy0), 0);
        if (out_valid) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            if (check_out) chk(tag, int'(got), int'(exp_q.pop_front()));
        end else begin
            chk({tag, "_out_timeout"}, lat, 0);
            if (check_out) void'(exp_q.pop_front());
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] got;
        logic [4:0] got2;
        logic [4:0] held;
        logic       stable;
        logic       seen;
        int         guard;

        reset        = 1'b1;
        load_en      = 1'b0;
        load_pos     = '0;
        ring_setting = '0;
        wiring_sel   = {2'd0, 2'd1, 2'd2};
        in_valid     = 1'b0;
        in_letter    = '0;
        out_ready    = 1'b0;

        @(negedge clk);
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_letter", int'(out_letter), 0);
        chk("rst_positions", int'(positions), 0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", int'(in_ready), 1);
        @(negedge clk);

        // I-II-III, rings AAA, start AAA: AAAAA -> BDZGO
        for (int k = 0; k < 5; k++) begin
            run_txn("bdzgo", 5'd0, 0, 1'b1, bdzgo[k], got);
            if (k == 0) begin
                chk("latency", last_lat, 8);
                chk("pos_edge0", int'(pos_e0), int'(p3(0, 0, 0)));
                chk("pos_edge1", int'(pos_e1), int'(p3(0, 0, 1)));
            end
        end
        chk("pos_AAF", int'(positions), int'(p3(0, 0, 5)));

        // double stepping from ADU
        pulse_load(p3(0, 3, 20));
        chk("pos_ADU", int'(positions), int'(p3(0, 3, 20)));
        run_txn("ds1", 5'd0, 0, 1'b0, 5'd0, got);
        chk("pos_ADV", int'(positions), int'(p3(0, 3, 21)));
        run_txn("ds2", 5'd0, 0, 1'b0, 5'd0, got);
        chk("pos_AEW", int'(positions), int'(p3(0, 4, 22)));
        run_txn("ds3", 5'd0, 0, 1'b0, 5'd0, got);
        chk("pos_BFX", int'(positions), int'(p3(1, 5, 23)));

        // rings BBB: A -> E
        pulse_load(p3(0, 0, 0));
        ring_setting = p3(1, 1, 1);
        run_txn("ring_bbb", 5'd0, 0, 1'b1, 5'd4, got);

        // identity rotors: output is the reflector alone; load folds >=26
        wiring_sel   = '1;
        ring_setting = p3(3, 9, 20);
        pulse_load(p3(30, 27, 26));
        chk("load_fold", int'(positions), int'(p3(4, 1, 0)));
        run_txn("ident_A", 5'd0, 0, 1'b1, 5'd24, got);
        run_txn("ident_Q", 5'd16, 0, 1'b1, 5'd4, got);
        run_txn("ident_Y", 5'd24, 0, 1'b1, 5'd0, got);

        // reciprocity from the same start position
        wiring_sel   = {2'd0, 2'd1, 2'd2};
        ring_setting = p3(5, 2, 11);
        for (int k = 0; k < 4; k++) begin
            pulse_load(p3(2, 17, 8));
            run_txn("rt_enc", rt_in[k], 0, 1'b0, 5'd0, got);
            chk("no_self_map", int'(got != rt_in[k]), 1);
            pulse_load(p3(2, 17, 8));
            run_txn("round_trip", got, 0, 1'b1, rt_in[k], got2);
        end

        // backpressure
        ring_setting = '0;
        pulse_load(p3(0, 0, 0));
        exp_q.push_back(5'd1);
        in_letter = 5'd0;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        guard = 0;
        while (!out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("bp_valid_rose", int'(out_valid), 1);
        held   = out_letter;
        stable = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!out_valid || out_letter !== held || in_ready) stable = 1'b0;
        end
        chk("bp_stable", int'(stable), 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_letter", int'(held), int'(exp_q.pop_front()));
        chk("bp_valid_fell", int'(out_valid), 0);
        chk("bp_in_ready", int'(in_ready), 1);

        // reset during FWD aborts the transaction
        in_letter = 5'd0;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_in_ready_rst", int'(in_ready), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_positions", int'(positions), 0);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_in_ready", int'(in_ready), 1);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_valid", int'(seen), 0);

        // load_en ignored mid-transaction and dropped on the accept edge
        run_txn("load_mid", 5'd0, 1, 1'b1, 5'd1, got);
        chk("load_mid_pos", int'(positions), int'(p3(0, 0, 1)));
        run_txn("load_acc", 5'd0, 2, 1'b1, 5'd3, got);
        chk("load_acc_pos", int'(positions), int'(p3(0, 0, 2)));

        // out-of-range letter passes through, no stepping
        run_txn("bypass27", 5'd27, 0, 1'b1, 5'd27, got);
        chk("bypass_latency", last_lat, 8);
        chk("bypass_pos", int'(positions), int'(p3(0, 0, 2)));
        run_txn("bypass31", 5'd31, 0, 1'b1, 5'd31, got);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
